stopwatch_lap_core: RTL and testbench
=====================================

// Module: stopwatch_lap_core
// PURPOSE
//  Stopwatch timebase with a lap-record FIFO. Replaces the single-register timer.
//  Keeps HH:MM:SS.CC directly in BCD and captures split or lap times into a LAP_DEPTH FIFO.
//  The LCD bridge drains the FIFO through a valid/ready interface.
//  Sits between the key FSM (debounced 1-cycle pulses) and the 7-seg/LCD converters.
// PARAMETERS
//  CLK_HZ     50_000_000  input clock frequency
//  TICK_HZ    100         centisecond tick rate; CLK_HZ/TICK_HZ must be an integer >= 2
//  LAP_DEPTH  8           lap FIFO entries, power of two, >= 2
// PORTS
//  clock        in   1   system clock
//  reset_n      in   1   asynchronous active-low reset
//  start_pause  in   1   1-cycle pulse: IDLE/PAUSE->RUN, RUN->PAUSE
//  lap          in   1   1-cycle pulse: capture record (RUN only)
//  clear_time   in   1   1-cycle pulse: zero timers, go IDLE (ignored in RUN)
//  clear_laps   in   1   1-cycle pulse: flush FIFO, clear lap_overrun
//  lap_mode     in   1   0 = split (total time), 1 = lap (time since last capture)
//  running      out  1   high in RUN
//  time_bcd     out  32  {H1,H0,M1,M0,S1,S0,C1,C0}, 4-bit BCD digits, total time
//  lap_valid    out  1   FIFO non-empty
//  lap_ready    in   1   consumer accepts head when lap_valid&&lap_ready
//  lap_data     out  32  FIFO head, same format as time_bcd; holds last value when empty
//  lap_count    out  $clog2(LAP_DEPTH)+1  entries stored
//  lap_overrun  out  1   sticky: a capture was dropped because the FIFO was full
//  time_wrap    out  1   sticky: total time wrapped 99:59:59.99 -> 0
// BEHAVIOUR
//  Reset: state IDLE. Total timer, lap timer, prescaler, FIFO, lap_data all zero.
//   running, lap_valid, lap_count, lap_overrun, time_wrap all 0.
//  FSM: IDLE -start_pause-> RUN; RUN -start_pause-> PAUSE; PAUSE -start_pause-> RUN.
//   clear_time in IDLE/PAUSE -> IDLE: zeroes total timer, lap timer, prescaler, time_wrap.
//   clear_time in RUN is ignored.
//  Prescaler: counts 0..CLK_HZ/TICK_HZ-1 only in RUN; tick on terminal count.
//   Value is held in PAUSE, so a resume continues the partial tick.
//  BCD cascade on tick: CC 00-99 -> SS 00-59 -> MM 00-59 -> HH 00-99.
//   Each digit field only ever holds legal BCD.
//   HH 99 carry wraps all fields to 0 and sets time_wrap.
//   The lap timer is an identical cascade that wraps silently.
//  time_bcd is registered and updates the cycle after the tick.
//  Capture: lap pulse in RUN pushes one record.
//   Record = total time (lap_mode=0) or lap timer (lap_mode=1), taken before any same-cycle tick.
//   The lap timer restarts at 00:00:00.00 in both modes, or at .01 if a tick coincides.
//   lap pulse in IDLE/PAUSE is ignored.
//  FIFO: pushed entry is visible on lap_valid/lap_data the next cycle. Pop on lap_valid&&lap_ready.
//   Push when full and no pop: record dropped, lap_overrun set, lap timer still restarts.
//   Push and pop in the same cycle: both occur and count is unchanged, even when full.
//   Pop when empty: no effect.
//   Read/write pointers wrap modulo LAP_DEPTH. lap_count = LAP_DEPTH exactly when full.
//  Simultaneous events:
//   start_pause+lap in RUN: capture uses the pre-pause time, then PAUSE.
//   clear_laps+push: clear wins, push discarded, lap_overrun = 0.
//   clear_laps+pop: FIFO empty next cycle.
//   clear_time+clear_laps in PAUSE: both act.
//  reset_n low mid-operation: all state returns to reset values immediately.
//   No partial FIFO write survives.
// TESTING (CLK_HZ=1000, TICK_HZ=100 -> 10 clocks/tick, LAP_DEPTH=4)
//  1. start_pause, run 1000 clocks -> time_bcd=32'h0000_0100, running=1;
//     start_pause, 50 idle clocks -> value unchanged.
//  2. Preload to 99:59:59.99, one tick -> time_bcd=0, time_wrap=1;
//     clear_time in PAUSE -> time_wrap=0.
//  3. lap_mode=1, laps at 30 and 80 ticks, lap_ready=0 -> lap_count=2;
//     FIFO drains 00..00.30 then 00..00.50.
//  4. lap_mode=0, 5 laps with lap_ready=0 -> lap_count=4, lap_overrun=1, 5th record absent;
//     clear_laps -> lap_valid=0, lap_overrun=0.
//  5. FIFO full, lap and pop in the same cycle -> lap_count stays 4,
//     new record at tail, lap_overrun=0.
//  6. clear_time while RUN -> ignored; lap in PAUSE -> no push;
//     reset_n low mid-count -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/stopwatch_lap_core.sv
// stopwatch_lap_core
//   Stopwatch timebase that counts HH:MM:SS.CC directly in BCD, plus a FIFO
//   of captured split/lap records. The FIFO is drained through valid/ready.
//
// Parameters
//   CLK_HZ       input clock frequency
//   TICK_HZ      centisecond tick rate (CLK_HZ/TICK_HZ integer, >= 2)
//   LAP_DEPTH    lap FIFO entries (power of two, >= 2)
//   PRESET_TIME  value the total timer takes on reset; 0 in normal use,
//                nonzero only for bring-up near the 99:59:59.99 rollover
//
// Ports
//   clock, reset_n  system clock, asynchronous active-low reset
//   start_pause     pulse: IDLE/PAUSE -> RUN, RUN -> PAUSE
//   lap             pulse: capture a record while running
//   clear_time      pulse: zero timers and return to IDLE (ignored in RUN)
//   clear_laps      pulse: flush FIFO and clear lap_overrun
//   lap_mode        0 = record total time, 1 = record time since last capture
//   running         high in RUN
//   time_bcd        {H1,H0,M1,M0,S1,S0,C1,C0} total time
//   lap_valid       FIFO non-empty
//   lap_ready       consumer pops head when lap_valid && lap_ready
//   lap_data        FIFO head; holds the last head when the FIFO empties
//   lap_count       entries stored
//   lap_overrun     sticky: a capture was dropped on a full FIFO
//   time_wrap       sticky: total time rolled over 99:59:59.99 -> 0
module stopwatch_lap_core #(
    parameter int          CLK_HZ      = 50_000_000,
    parameter int          TICK_HZ     = 100,
    parameter int          LAP_DEPTH   = 8,
    parameter logic [31:0] PRESET_TIME = 32'h0
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         start_pause,
    input  logic                         lap,
    input  logic                         clear_time,
    input  logic                         clear_laps,
    input  logic                         lap_mode,
    output logic                         running,
    output logic [31:0]                  time_bcd,
    output logic                         lap_valid,
    input  logic                         lap_ready,
    output logic [31:0]                  lap_data,
    output logic [$clog2(LAP_DEPTH):0]   lap_count,
    output logic                         lap_overrun,
    output logic                         time_wrap
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = $clog2(DIV);
    localparam int AW  = $clog2(LAP_DEPTH);
    localparam int CW  = AW + 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(LAP_DEPTH);
    localparam logic [31:0]   TIME_MAX   = 32'h9959_5999;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;

    // One-centisecond increment of an HH:MM:SS.CC BCD word. The tens digits
    // of seconds and minutes (nibbles 3 and 5) roll at 5, all others at 9.
    // The carry out of H1 is dropped, so 99:59:59.99 becomes all zeros.
    function automatic logic [31:0] bcd_inc(input logic [31:0] t);
        logic [31:0] q;
        logic        c;
        logic [3:0]  d;
        logic [3:0]  lim;
        q = t;
        c = 1'b1;
        for (int i = 0; i < 8; i++) begin
            d   = t[4*i +: 4];
            lim = (i == 3 || i == 5) ? 4'd5 : 4'd9;
            if (c) begin
                if (d == lim) begin
                    q[4*i +: 4] = 4'd0;
                end else begin
                    q[4*i +: 4] = d + 4'd1;
                    c           = 1'b0;
                end
            end
        end
        return q;
    endfunction

    logic [1:0]    state_q;
    logic [PW-1:0] presc_q;
    logic [31:0]   total_q;
    logic [31:0]   lap_t_q;
    logic          time_wrap_q;

    logic [31:0]   mem [LAP_DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [31:0]   head_q;
    logic          overrun_q;

    logic          is_run;
    logic          tick;
    logic          push_req;
    logic [31:0]   record;
    logic          full;
    logic          do_pop;
    logic          do_push;
    logic          drop;
    logic [AW-1:0] rd_ptr_nxt;

    assign is_run     = (state_q == S_RUN);
    assign tick       = is_run && (presc_q == PRESC_LAST);
    assign push_req   = lap && is_run;
    // Record is taken from the register values, i.e. before any same-cycle tick.
    assign record     = lap_mode ? lap_t_q : total_q;
    assign full       = (count_q == FULL_COUNT);
    assign do_pop     = (count_q != '0) && lap_ready;
    // A pop frees the slot in the same cycle, so a full FIFO still accepts a push.
    assign do_push    = push_req && !clear_laps && (!full || do_pop);
    assign drop       = push_req && !clear_laps && full && !do_pop;
    assign rd_ptr_nxt = rd_ptr_q + 1'b1;

    // Control FSM, prescaler and the two BCD timers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            presc_q     <= '0;
            total_q     <= PRESET_TIME;
            lap_t_q     <= '0;
            time_wrap_q <= 1'b0;
        end else if (clear_time && !is_run) begin
            state_q     <= S_IDLE;
            presc_q     <= '0;
            total_q     <= '0;
            lap_t_q     <= '0;
            time_wrap_q <= 1'b0;
        end else begin
            if (start_pause) begin
                state_q <= is_run ? S_PAUSE : S_RUN;
            end
            // Held outside RUN so that a resume finishes the partial tick.
            if (is_run) begin
                presc_q <= tick ? '0 : presc_q + 1'b1;
            end
            if (tick) begin
                total_q <= bcd_inc(total_q);
                if (total_q == TIME_MAX) begin
                    time_wrap_q <= 1'b1;
                end
            end
            // A capture restarts the lap timer even when the record is dropped;
            // a coinciding tick is already counted in the fresh lap.
            if (push_req) begin
                lap_t_q <= tick ? 32'h0000_0001 : 32'h0000_0000;
            end else if (tick) begin
                lap_t_q <= bcd_inc(lap_t_q);
            end
        end
    end

    // Lap FIFO with a registered head so lap_data holds its value when empty
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < LAP_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            head_q    <= '0;
            overrun_q <= 1'b0;
        end else if (clear_laps) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (do_push) begin
                mem[wr_ptr_q] <= record;
                wr_ptr_q      <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_nxt;
            end
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
            if (drop) begin
                overrun_q <= 1'b1;
            end
            // Next head: the following stored entry after a pop, the incoming
            // record when it lands in an empty (or just-emptied) FIFO, else hold.
            if (do_pop) begin
                if (count_q == CW'(1)) begin
                    if (do_push) begin
                        head_q <= record;
                    end
                end else begin
                    head_q <= mem[rd_ptr_nxt];
                end
            end else if (do_push && count_q == '0) begin
                head_q <= record;
            end
        end
    end

    assign running     = is_run;
    assign time_bcd    = total_q;
    assign time_wrap   = time_wrap_q;
    assign lap_valid   = (count_q != '0);
    assign lap_data    = head_q;
    assign lap_count   = count_q;
    assign lap_overrun = overrun_q;

endmodule

// File: tb/tb_stopwatch_lap_core.sv
// tb_stopwatch_lap_core
//   Bench for stopwatch_lap_core at CLK_HZ=1000, TICK_HZ=100 (10 clocks per
//   centisecond), LAP_DEPTH=4. A reference model keeps time as integer
//   centiseconds and the FIFO as a queue; a second instance with a preset
//   total time exercises the 99:59:59.99 rollover.
module tb_stopwatch_lap_core;

    localparam int CLK_HZ = 1000;
    localparam int TICK_HZ = 100;
    localparam int DEPTH = 4;
    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int WRAP_CS = 36000000;  // 100 hours in centiseconds

    logic        clock;
    logic        reset_n;
    logic        start_pause, lap, clear_time, clear_laps, lap_mode, lap_ready;
    logic        running, lap_valid, lap_overrun, time_wrap;
    logic [31:0] time_bcd, lap_data;
    logic [2:0]  lap_count;

    logic        w_rst_n, w_sp, w_lap, w_ct, w_cl, w_lm, w_rdy;
    logic        w_running, w_valid, w_ovr, w_wrap;
    logic [31:0] w_time, w_data;
    logic [2:0]  w_count;

    int checks = 0;
    int errors = 0;

    stopwatch_lap_core #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .LAP_DEPTH(DEPTH)) u_dut (
        .clock(clock), .reset_n(reset_n), .start_pause(start_pause), .lap(lap),
        .clear_time(clear_time), .clear_laps(clear_laps), .lap_mode(lap_mode),
        .running(running), .time_bcd(time_bcd), .lap_valid(lap_valid),
        .lap_ready(lap_ready), .lap_data(lap_data), .lap_count(lap_count),
        .lap_overrun(lap_overrun), .time_wrap(time_wrap)
    );

    stopwatch_lap_core #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .LAP_DEPTH(DEPTH),
                         .PRESET_TIME(32'h9959_5999)) u_wrap (
        .clock(clock), .reset_n(w_rst_n), .start_pause(w_sp), .lap(w_lap),
        .clear_time(w_ct), .clear_laps(w_cl), .lap_mode(w_lm),
        .running(w_running), .time_bcd(w_time), .lap_valid(w_valid),
        .lap_ready(w_rdy), .lap_data(w_data), .lap_count(w_count),
        .lap_overrun(w_ovr), .time_wrap(w_wrap)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- reference model ----------------
    int          m_state;   // 0 idle, 1 run, 2 pause
    int          m_presc;
    int          m_total;   // centiseconds
    int          m_lap;     // centiseconds
    bit          m_wrap;
    bit          m_ovr;
    logic [31:0] m_fifo[$];
    logic [31:0] m_last;

    function automatic logic [31:0] to_bcd(input int cs);
        int h, m, s, c;
        h = cs / 360000;
        m = (cs / 6000) % 60;
        s = (cs / 100) % 60;
        c = cs % 100;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10),
                4'(s / 10), 4'(s % 10), 4'(c / 10), 4'(c % 10)};
    endfunction

    task automatic model_reset();
        m_state = 0; m_presc = 0; m_total = 0; m_lap = 0;
        m_wrap = 0; m_ovr = 0; m_last = '0;
        m_fifo.delete();
    endtask

    task automatic model_step();
        bit          run, tick, push_req, pop;
        logic [31:0] rec;
        run      = (m_state == 1);
        tick     = run && (m_presc == DIV - 1);
        push_req = lap && run;
        rec      = lap_mode ? to_bcd(m_lap) : to_bcd(m_total);
        pop      = (m_fifo.size() > 0) && lap_ready;
        if (clear_time && !run) begin
            m_state = 0; m_presc = 0; m_total = 0; m_lap = 0; m_wrap = 0;
        end else begin
            if (start_pause) m_state = run ? 2 : 1;
            if (run) m_presc = tick ? 0 : m_presc + 1;
            if (tick) begin
                m_total = m_total + 1;
                if (m_total == WRAP_CS) begin
                    m_total = 0;
                    m_wrap  = 1;
                end
            end
            if (push_req) m_lap = tick ? 1 : 0;
            else if (tick) m_lap = (m_lap + 1) % WRAP_CS;
        end
        if (clear_laps) begin
            m_fifo.delete();
            m_ovr = 0;
        end else begin
            if (pop) void'(m_fifo.pop_front());
            if (push_req) begin
                if (m_fifo.size() < DEPTH) m_fifo.push_back(rec);
                else m_ovr = 1;
            end
        end
        if (m_fifo.size() > 0) m_last = m_fifo[0];
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("model running",   32'(running),     32'(m_state == 1));
        chk("model time_bcd",  time_bcd,         to_bcd(m_total));
        chk("model lap_valid", 32'(lap_valid),   32'(m_fifo.size() != 0));
        chk("model lap_data",  lap_data,         m_last);
        chk("model lap_count", 32'(lap_count),   32'(m_fifo.size()));
        chk("model overrun",   32'(lap_overrun), 32'(m_ovr));
        chk("model time_wrap", 32'(time_wrap),   32'(m_wrap));
    endtask

    // One clock: DUT and model both consume the current inputs.
    task automatic cyc();
        @(posedge clock);
        model_step();
        @(negedge clock);
        check_model();
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cyc();
    endtask

    task automatic drive(input bit sp, input bit lp, input bit ct, input bit cl);
        start_pause = sp; lap = lp; clear_time = ct; clear_laps = cl;
        cyc();
        start_pause = 0; lap = 0; clear_time = 0; clear_laps = 0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit          sp, lp, ct, cl;
        int          idle;
        bit          er;
        logic [31:0] et;
        int          ec;
        bit          eo;
        logic [31:0] ed;
    } vec_t;

    function automatic vec_t mk(bit sp, bit lp, bit ct, bit cl, int idle,
                                bit er, logic [31:0] et, int ec, bit eo, logic [31:0] ed);
        vec_t v;
        v.sp = sp; v.lp = lp; v.ct = ct; v.cl = cl; v.idle = idle;
        v.er = er; v.et = et; v.ec = ec; v.eo = eo; v.ed = ed;
        return v;
    endfunction

    vec_t tbl[10];

    logic [31:0] drain_exp[3];

    initial begin
        //            sp lp ct cl idle  run time          cnt ovr data
        tbl[0] = mk(1, 0, 0, 0, 1000, 1, 32'h0000_0100, 0, 0, 32'h0);
        tbl[1] = mk(1, 0, 0, 0, 50,   0, 32'h0000_0100, 0, 0, 32'h0);
        tbl[2] = mk(0, 0, 1, 0, 0,    0, 32'h0000_0000, 0, 0, 32'h0);
        tbl[3] = mk(1, 0, 0, 0, 14,   1, 32'h0000_0001, 0, 0, 32'h0);
        tbl[4] = mk(0, 1, 0, 0, 29,   1, 32'h0000_0004, 1, 0, 32'h1);
        tbl[5] = mk(0, 1, 0, 0, 29,   1, 32'h0000_0007, 2, 0, 32'h1);
        tbl[6] = mk(0, 1, 0, 0, 29,   1, 32'h0000_0010, 3, 0, 32'h1);
        tbl[7] = mk(0, 1, 0, 0, 29,   1, 32'h0000_0013, 4, 0, 32'h1);
        tbl[8] = mk(0, 1, 0, 0, 29,   1, 32'h0000_0016, 4, 1, 32'h1);
        tbl[9] = mk(0, 0, 0, 1, 0,    1, 32'h0000_0016, 0, 0, 32'h1);

        reset_n = 0; start_pause = 0; lap = 0; clear_time = 0; clear_laps = 0;
        lap_mode = 0; lap_ready = 0;
        w_rst_n = 0; w_sp = 0; w_lap = 0; w_ct = 0; w_cl = 0; w_lm = 0; w_rdy = 0;
        model_reset();
        repeat (3) @(negedge clock);

        // reset state
        chk("reset running",   32'(running),     32'h0);
        chk("reset time_bcd",  time_bcd,         32'h0);
        chk("reset lap_valid", 32'(lap_valid),   32'h0);
        chk("reset lap_data",  lap_data,         32'h0);
        chk("reset lap_count", 32'(lap_count),   32'h0);
        chk("reset overrun",   32'(lap_overrun), 32'h0);
        chk("reset time_wrap", 32'(time_wrap),   32'h0);
        reset_n = 1;
        cyc();

        // table: run/pause/clear and a split-mode FIFO overrun
        for (int i = 0; i < 10; i++) begin
            start_pause = tbl[i].sp; lap = tbl[i].lp;
            clear_time = tbl[i].ct; clear_laps = tbl[i].cl;
            cyc();
            start_pause = 0; lap = 0; clear_time = 0; clear_laps = 0;
            run(tbl[i].idle);
            chk($sformatf("vec%0d running", i),   32'(running),     32'(tbl[i].er));
            chk($sformatf("vec%0d time_bcd", i),  time_bcd,         tbl[i].et);
            chk($sformatf("vec%0d lap_count", i), 32'(lap_count),   32'(tbl[i].ec));
            chk($sformatf("vec%0d lap_valid", i), 32'(lap_valid),   32'(tbl[i].ec != 0));
            chk($sformatf("vec%0d overrun", i),   32'(lap_overrun), 32'(tbl[i].eo));
            chk($sformatf("vec%0d lap_data", i),  lap_data,         tbl[i].ed);
        end

        // pause, then clear_time and clear_laps together
        drive(1, 0, 0, 0);
        drive(0, 0, 1, 1);
        chk("dual clear time",    time_bcd,       32'h0);
        chk("dual clear running", 32'(running),   32'h0);
        chk("dual clear count",   32'(lap_count), 32'h0);

        // lap mode: captures at 30 and 80 ticks give 0.30 and 0.50
        lap_mode = 1;
        drive(1, 0, 0, 0);
        run(300);
        drive(0, 1, 0, 0);
        run(499);
        drive(0, 1, 0, 0);
        chk("lapmode count", 32'(lap_count), 32'h2);
        chk("lapmode head0", lap_data,       32'h0000_0030);
        lap_ready = 1;
        cyc();
        chk("lapmode head1",  lap_data,       32'h0000_0050);
        chk("lapmode count1", 32'(lap_count), 32'h1);
        cyc();
        chk("lapmode empty valid", 32'(lap_valid), 32'h0);
        chk("lapmode hold data",   lap_data,       32'h0000_0050);
        lap_ready = 0;

        // full FIFO with push and pop in the same cycle
        drive(1, 0, 0, 0);
        drive(0, 0, 1, 1);
        lap_mode = 0;
        drive(1, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            run(k == 0 ? 100 : 99);
            drive(0, 1, 0, 0);
        end
        chk("full count",   32'(lap_count),   32'h4);
        chk("full overrun", 32'(lap_overrun), 32'h0);
        run(99);
        lap = 1; lap_ready = 1;
        cyc();
        lap = 0;
        chk("pushpop count",   32'(lap_count),   32'h4);
        chk("pushpop overrun", 32'(lap_overrun), 32'h0);
        chk("pushpop head",    lap_data,         32'h0000_0020);
        drain_exp[0] = 32'h0000_0030;
        drain_exp[1] = 32'h0000_0040;
        drain_exp[2] = 32'h0000_0050;
        for (int j = 0; j < 3; j++) begin
            cyc();
            chk($sformatf("drain%0d data", j), lap_data, drain_exp[j]);
        end
        cyc();
        chk("drain empty", 32'(lap_valid), 32'h0);
        lap_ready = 0;

        // clear_time ignored in RUN, lap ignored in PAUSE
        drive(0, 0, 1, 0);
        chk("run clear running", 32'(running), 32'h1);
        chk("run clear time",    time_bcd,     32'h0000_0050);
        drive(1, 0, 0, 0);
        drive(0, 1, 0, 0);
        chk("pause lap count", 32'(lap_count), 32'h0);
        chk("pause lap time",  time_bcd,       32'h0000_0050);

        // asynchronous reset mid-count
        drive(1, 0, 0, 0);
        lap_mode = 1;
        drive(0, 1, 0, 0);
        run(37);
        reset_n = 0;
        #1;
        chk("async running",   32'(running),     32'h0);
        chk("async time_bcd",  time_bcd,         32'h0);
        chk("async lap_valid", 32'(lap_valid),   32'h0);
        chk("async lap_data",  lap_data,         32'h0);
        chk("async lap_count", 32'(lap_count),   32'h0);
        chk("async overrun",   32'(lap_overrun), 32'h0);
        chk("async time_wrap", 32'(time_wrap),   32'h0);
        model_reset();
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1;
        cyc();

        // randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            start_pause = ($urandom_range(0, 39) == 0);
            lap         = ($urandom_range(0, 5) == 0);
            clear_time  = ($urandom_range(0, 79) == 0);
            clear_laps  = ($urandom_range(0, 59) == 0);
            lap_mode    = $urandom_range(0, 1) == 1;
            lap_ready   = ($urandom_range(0, 2) == 0);
            cyc();
        end
        start_pause = 0; lap = 0; clear_time = 0; clear_laps = 0; lap_ready = 0;

        // rollover on the preset instance
        w_rst_n = 1;
        @(negedge clock);
        chk("wrap preset", w_time, 32'h9959_5999);
        w_sp = 1;
        @(negedge clock);
        w_sp = 0;
        repeat (9) @(negedge clock);
        chk("wrap before time", w_time,       32'h9959_5999);
        chk("wrap before flag", 32'(w_wrap),  32'h0);
        @(negedge clock);
        chk("wrap after time",  w_time,       32'h0);
        chk("wrap after flag",  32'(w_wrap),  32'h1);
        w_sp = 1;
        @(negedge clock);
        w_sp = 0;
        chk("wrap paused flag", 32'(w_wrap),  32'h1);
        w_ct = 1;
        @(negedge clock);
        w_ct = 0;
        chk("wrap cleared flag",    32'(w_wrap),    32'h0);
        chk("wrap cleared running", 32'(w_running), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
